ipsxb_fft_test_ctrl: RTL and testbench
======================================

Name: ipsxb_fft_test_ctrl

Overview:
Parametrised on-board test sequencer for the FFT example design. It is the successor to the single-channel start/error logic.
- Debounces a raw start input and issues start pulses to CH_NUM frame_gen/frame_chk pairs.
- Tracks per-channel completion and latches per-channel errors and alarms.
- Adds a completion watchdog, continuous (auto-repeat) mode and a saturating passed-run counter.
- Sits between board pins and the per-channel ipsxb_fft_frame_gen / ipsxb_fft_frame_chk instances.

Parameters:
CH_NUM, 1, number of FFT channels under test (1..8)
ALM_WIDTH, 3, alarm bits per channel
DB_CNT_MAX, 2048, debounce delay and continuous-mode inter-run gap, in enabled cycles
DB_CNT_WIDTH, 12, width of the debounce/gap counter; must satisfy 2^DB_CNT_WIDTH >= DB_CNT_MAX
TIMEOUT_MAX, 2^20, enabled cycles allowed in WAIT before timeout
TIMEOUT_WIDTH, 21, width of the watchdog counter
RUN_CNT_WIDTH, 16, width of the passed-run counter

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_aclken  in  1  clock enable from frame_gen; all state holds when low
i_start_test  in  1  raw asynchronous start button, active-high
i_continuous  in  1  1 = auto-repeat runs; sampled in DONE
i_chk_finished  in  CH_NUM  per-channel checker finished level
i_err  in  CH_NUM  per-channel checker error
i_alm  in  CH_NUM*ALM_WIDTH  per-channel FFT alarms; channel k occupies bits [k*ALM_WIDTH +: ALM_WIDTH]
o_start_pulse  out  1  one-enabled-cycle start to all gens/checkers
o_err_ch  out  CH_NUM  sticky per-channel error
o_err  out  1  OR of o_err_ch and o_timeout
o_timeout  out  1  sticky watchdog flag
o_busy  out  1  high in DEBOUNCE, START, WAIT, GAP
o_done  out  1  high in DONE
o_run_cnt  out  RUN_CNT_WIDTH  error-free completed runs, saturating

Behaviour:
- Reset and enable:
  - Synchronous reset when i_rst=1. All outputs go to 0, FSM goes to IDLE, counters clear, and the synchroniser loads 3'b111 so a held button does not fire.
  - Reset wins over every other event, including mid-run.
  - All registers except the synchroniser update only when i_aclken=1.
- Input sampling: i_start_test passes through a 3-flop synchroniser. A rise is defined as stage1=1 and stage2=0.
- FSM states: IDLE, DEBOUNCE, START, WAIT, DONE, GAP.
  - IDLE: on a rise, go to DEBOUNCE and load the debounce counter with 1.
  - DEBOUNCE: the counter increments each enabled cycle. At count DB_CNT_MAX-1, go to START. Button activity here is ignored.
  - START: o_start_pulse=1 for exactly one enabled cycle.
    - Clear o_err_ch, o_timeout, the fin mask and the watchdog.
    - Go to WAIT.
    - If an error arrives in the same cycle, the clear wins.
  - WAIT: fin[k] sets on a rising edge of i_chk_finished[k]. A level still high from the previous run does not count.
    - When all fin bits are 1, go to DONE. o_run_cnt increments if o_err=0 at that point, saturating at all-ones.
    - If the watchdog reaches TIMEOUT_MAX-1 first, set o_timeout and go to DONE with no increment.
    - If completion and timeout happen in the same cycle, completion wins.
  - DONE:
    - If i_continuous=1 and o_err=0, go to GAP with the counter at 1.
    - Otherwise stay in DONE. A new rise goes to DEBOUNCE.
  - GAP: count to DB_CNT_MAX-1, then go to START. A drop of i_continuous during GAP goes to DONE.
- Error latching:
  - o_err_ch[k] is set when i_err[k]=1 or i_alm channel k != 0.
  - Errors are sampled in every state except START. Errors in IDLE/DONE also latch, matching the legacy lock.
  - Bits are cleared only in START or by reset.
- Output registration: o_err is the registered OR of o_err_ch and o_timeout, with 1 enabled cycle of latency. All outputs are registered.

Decomposition:
- Package ipsxb_fft_test_pkg holds:
  - the FSM state encoding (3-bit localparams)
  - the default DB_CNT_MAX and TIMEOUT_MAX
  - a function for the clog2 width helper
- One natural sub-module, ipsxb_fft_start_sync: the 3-flop synchroniser plus rise detect, with parameterised reset value.
- Per-channel fin/err logic is a generate loop, not a sub-module.

Test Plan:
1. Reset, then pulse i_start_test for 5 cycles with DB_CNT_MAX=16, CH_NUM=2, aclken=1 -> o_start_pulse high exactly once, 17 cycles after the synchronised rise; o_busy=1 from DEBOUNCE onward.
2. Hold i_chk_finished=2'b11 from the previous run through START, raise ch0 only, then drop and re-raise ch1 -> DONE only after the ch1 re-rise; o_run_cnt=1, o_err=0.
3. Set i_alm ch1=3'b010 for one cycle during WAIT -> o_err_ch=2'b10 and o_err=1 one cycle later; at completion o_run_cnt unchanged; next START clears o_err_ch to 0.
4. TIMEOUT_MAX=64 with no finish edges -> o_timeout=1 after 64 WAIT cycles, state DONE; with i_continuous=1, no auto-restart occurs.
5. i_continuous=1, with a clean finish each run and RUN_CNT_WIDTH=2 -> runs repeat with a 16-cycle gap; o_run_cnt reads 1,2,3,3 (saturates).
6. Assert i_rst mid-WAIT while i_aclken toggles 0/1 -> next cycle all outputs are 0 and the state is IDLE; while aclken=0 the counters are verified frozen.

Source files
------------

// File: rtl/ipsxb_fft_test_pkg.sv
// rtl/ipsxb_fft_test_pkg.sv - state encoding and defaults for the FFT test sequencer
package ipsxb_fft_test_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DEBOUNCE = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_DEBOUNCE = S_DEBOUNCE,
        ST_START    = S_START,
        ST_WAIT     = S_WAIT,
        ST_DONE     = S_DONE,
        ST_GAP      = S_GAP
    } state_t;

    // Smallest w with 2^w >= value.
    function automatic int clog2_w(input int value);
        int w;
        w = 1;
        while (w < 31 && (32'sd1 << w) < value) w = w + 1;
        return w;
    endfunction

    localparam int DEF_DB_CNT_MAX     = 2048;
    localparam int DEF_TIMEOUT_MAX    = 1 << 20;
    // One bit of headroom above the terminal count.
    localparam int DEF_DB_CNT_WIDTH   = clog2_w(DEF_DB_CNT_MAX) + 1;
    localparam int DEF_TIMEOUT_WIDTH  = clog2_w(DEF_TIMEOUT_MAX) + 1;

endpackage

// File: rtl/ipsxb_fft_start_sync.sv
// rtl/ipsxb_fft_start_sync.sv - 3-flop start-button synchroniser with rise detect
module ipsxb_fft_start_sync #(
    parameter logic [2:0] RST_VAL = 3'b111
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_rise
);

    logic [2:0] sync;

    // Free-running: the button is tracked even while the clock enable is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync <= RST_VAL;
        end else begin
            sync <= {sync[1:0], i_din};
        end
    end

    assign o_rise = sync[1] & ~sync[2];

endmodule

// File: rtl/ipsxb_fft_test_ctrl.sv
// rtl/ipsxb_fft_test_ctrl.sv - multi-channel FFT test sequencer with watchdog and auto-repeat
module ipsxb_fft_test_ctrl
    import ipsxb_fft_test_pkg::*;
#(
    parameter int CH_NUM        = 1,
    parameter int ALM_WIDTH     = 3,
    parameter int DB_CNT_MAX    = DEF_DB_CNT_MAX,
    parameter int DB_CNT_WIDTH  = DEF_DB_CNT_WIDTH,
    parameter int TIMEOUT_MAX   = DEF_TIMEOUT_MAX,
    parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH,
    parameter int RUN_CNT_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_aclken,
    input  logic                          i_start_test,
    input  logic                          i_continuous,
    input  logic [CH_NUM-1:0]             i_chk_finished,
    input  logic [CH_NUM-1:0]             i_err,
    input  logic [CH_NUM*ALM_WIDTH-1:0]   i_alm,
    output logic                          o_start_pulse,
    output logic [CH_NUM-1:0]             o_err_ch,
    output logic                          o_err,
    output logic                          o_timeout,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [RUN_CNT_WIDTH-1:0]      o_run_cnt
);

    localparam logic [DB_CNT_WIDTH-1:0]  DB_ONE  = DB_CNT_WIDTH'(1);
    localparam logic [DB_CNT_WIDTH-1:0]  DB_LAST = DB_CNT_WIDTH'(DB_CNT_MAX - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_MAX - 1);

    state_t                    state;
    logic [DB_CNT_WIDTH-1:0]   db_cnt;
    logic [TIMEOUT_WIDTH-1:0]  wd_cnt;
    logic                      start_rise;
    logic [CH_NUM-1:0]         fin_set;
    logic [CH_NUM-1:0]         err_hit;
    logic                      all_fin;
    logic                      err_now;

    ipsxb_fft_start_sync #(
        .RST_VAL(3'b111)
    ) u_start_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_din  (i_start_test),
        .o_rise (start_rise)
    );

    // A finish level carried over from the previous run never counts: only edges set fin.
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic fin_q;
        logic err_q;
        logic chk_q;

        assign fin_set[k]  = fin_q | (i_chk_finished[k] & ~chk_q);
        assign err_hit[k]  = i_err[k] | (|i_alm[k*ALM_WIDTH +: ALM_WIDTH]);
        assign o_err_ch[k] = err_q;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                fin_q <= 1'b0;
                err_q <= 1'b0;
                chk_q <= 1'b0;
            end else if (i_aclken) begin
                chk_q <= i_chk_finished[k];
                if (state == ST_START) begin
                    fin_q <= 1'b0;
                    err_q <= 1'b0;
                end else begin
                    if (state == ST_WAIT) fin_q <= fin_set[k];
                    err_q <= err_q | err_hit[k];
                end
            end
        end
    end

    assign all_fin = &fin_set;
    assign err_now = o_err | o_timeout | (|o_err_ch);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            db_cnt        <= '0;
            wd_cnt        <= '0;
            o_start_pulse <= 1'b0;
            o_err         <= 1'b0;
            o_timeout     <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_run_cnt     <= '0;
        end else if (i_aclken) begin
            o_start_pulse <= 1'b0;
            o_err         <= (|o_err_ch) | o_timeout;
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        state  <= ST_DEBOUNCE;
                        db_cnt <= DB_ONE;
                        o_busy <= 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (db_cnt == DB_LAST) state <= ST_START;
                    else db_cnt <= db_cnt + 1'b1;
                end
                ST_START: begin
                    o_start_pulse <= 1'b1;
                    o_timeout     <= 1'b0;
                    wd_cnt        <= '0;
                    state         <= ST_WAIT;
                end
                // Completion is checked before the watchdog so it wins a same-cycle tie.
                ST_WAIT: begin
                    if (all_fin) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        if (!o_err && o_run_cnt != '1) o_run_cnt <= o_run_cnt + 1'b1;
                    end else if (wd_cnt == TO_LAST) begin
                        o_timeout <= 1'b1;
                        state     <= ST_DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_continuous && !err_now) begin
                        state  <= ST_GAP;
                        db_cnt <= DB_ONE;
                        o_busy <= 1'b1;
                        o_done <= 1'b0;
                    end else if (start_rise) begin
                        state  <= ST_DEBOUNCE;
                        db_cnt <= DB_ONE;
                        o_busy <= 1'b1;
                        o_done <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (!i_continuous) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else if (db_cnt == DB_LAST) begin
                        state <= ST_START;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipsxb_fft_test_ctrl.sv
// tb/tb_ipsxb_fft_test_ctrl.sv - scoreboard bench for the FFT test sequencer
module tb_ipsxb_fft_test_ctrl;

    localparam int CH = 2;
    localparam int AW = 3;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_aclken = 1'b1;
    logic              i_start_test = 1'b0;
    logic              i_continuous = 1'b0;
    logic [CH-1:0]     i_chk_finished = '0;
    logic [CH-1:0]     i_err = '0;
    logic [CH*AW-1:0]  i_alm = '0;
    logic              o_start_pulse;
    logic [CH-1:0]     o_err_ch;
    logic              o_err;
    logic              o_timeout;
    logic              o_busy;
    logic              o_done;
    logic [1:0]        o_run_cnt;

    typedef struct packed {
        logic [1:0] run;
        logic [1:0] err_ch;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   vec = 0;
    int   miscmp = 0;
    int   cyc = 0;
    int   n_pulse = 0;
    int   pc = 0;
    int   dc = 0;
    int   c0 = 0;
    int   np0 = 0;

    ipsxb_fft_test_ctrl #(
        .CH_NUM        (CH),
        .ALM_WIDTH     (AW),
        .DB_CNT_MAX    (16),
        .DB_CNT_WIDTH  (5),
        .TIMEOUT_MAX   (64),
        .TIMEOUT_WIDTH (7),
        .RUN_CNT_WIDTH (2)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_aclken       (i_aclken),
        .i_start_test   (i_start_test),
        .i_continuous   (i_continuous),
        .i_chk_finished (i_chk_finished),
        .i_err          (i_err),
        .i_alm          (i_alm),
        .o_start_pulse  (o_start_pulse),
        .o_err_ch       (o_err_ch),
        .o_err          (o_err),
        .o_timeout      (o_timeout),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_run_cnt      (o_run_cnt)
    );

    initial forever #5 i_clk = ~i_clk;

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    initial forever begin
        @(negedge i_clk);
        if (o_start_pulse === 1'b1) n_pulse++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic push(input int run, input logic [1:0] err_ch, input logic to);
        exp_t e;
        e.run    = 2'(run);
        e.err_ch = err_ch;
        e.to     = to;
        exp_q.push_back(e);
    endtask

    task automatic wait_pulse(input string name, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge i_clk);
            if (o_start_pulse === 1'b1) seen = 1'b1;
        end
        vec++;
        if (!seen) begin
            miscmp++;
            $display("FAIL %s: no start pulse within %0d cycles", name, max);
        end
    endtask

    task automatic wait_done(input string name, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) seen = 1'b1;
        end
        vec++;
        if (!seen) begin
            miscmp++;
            $display("FAIL %s: o_done not seen within %0d cycles", name, max);
        end
    endtask

    task automatic press(input int n);
        i_start_test = 1'b1;
        tick(n);
        i_start_test = 1'b0;
    endtask

    // Monitor: every entry into DONE is checked against the next queued expectation.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_done === 1'b1 && !prev_done) begin
                if (exp_q.size() == 0) begin
                    vec++;
                    miscmp++;
                    $display("FAIL done_unexpected: o_done rose with nothing queued, run_cnt %0d", o_run_cnt);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_run_cnt", 32'(o_run_cnt), 32'(e.run));
                    chk("done_err_ch", 32'(o_err_ch), 32'(e.err_ch));
                    chk("done_timeout", 32'(o_timeout), 32'(e.to));
                end
            end
            prev_done = (o_done === 1'b1);
        end
    end

    initial begin
        // Reset with the button held: synchroniser preload must suppress a start.
        i_start_test   = 1'b1;
        i_chk_finished = 2'b11;
        tick(3);
        chk("rst_outputs", 32'({o_start_pulse, o_err_ch, o_err, o_timeout, o_busy, o_done}), 32'd0);
        chk("rst_run_cnt", 32'(o_run_cnt), 32'd0);
        i_rst = 1'b0;
        tick(6);
        chk("held_button_no_fire", 32'(o_busy), 32'd0);
        i_start_test = 1'b0;
        tick(4);

        // 1: debounce latency, single pulse
        c0  = cyc;
        np0 = n_pulse;
        i_start_test = 1'b1;
        tick(2);
        chk("busy_before_debounce", 32'(o_busy), 32'd0);
        tick(1);
        chk("busy_in_debounce", 32'(o_busy), 32'd1);
        tick(2);
        i_start_test = 1'b0;
        wait_pulse("t1_pulse", 30);
        pc = cyc;
        chk("t1_start_latency", 32'(pc - c0), 32'd19);

        // 2: stale finish levels ignored, completion on ch1 re-rise
        chk("t2_busy_wait", 32'(o_busy), 32'd1);
        i_chk_finished = 2'b10;
        tick(2);
        i_chk_finished = 2'b11;
        tick(3);
        chk("t2_ch1_level_ignored", 32'(o_done), 32'd0);
        i_chk_finished = 2'b01;
        tick(2);
        chk("t2_ch0_only_not_done", 32'(o_done), 32'd0);
        push(1, 2'b00, 1'b0);
        i_chk_finished = 2'b11;
        wait_done("t2_done", 10);
        tick(1);
        chk("t2_err", 32'(o_err), 32'd0);
        chk("t2_pulses", 32'(n_pulse - np0), 32'd1);

        // 3: alarm on ch1 latches, blocks the run count
        press(3);
        wait_pulse("t3_pulse", 30);
        i_alm = 6'b010_000;
        tick(1);
        i_alm = '0;
        chk("t3_err_ch", 32'(o_err_ch), 32'd2);
        chk("t3_err_latency", 32'(o_err), 32'd0);
        tick(1);
        chk("t3_err", 32'(o_err), 32'd1);
        push(1, 2'b10, 1'b0);
        i_chk_finished = 2'b00;
        tick(1);
        i_chk_finished = 2'b11;
        wait_done("t3_done", 10);

        // 4: watchdog timeout, no auto-restart
        i_continuous = 1'b1;
        tick(3);
        chk("t4_err_blocks_repeat", 32'(o_done), 32'd1);
        press(3);
        wait_pulse("t4_pulse", 30);
        pc = cyc;
        chk("t4_start_clears_err_ch", 32'(o_err_ch), 32'd0);
        push(1, 2'b00, 1'b1);
        tick(1);
        chk("t4_err_cleared", 32'(o_err), 32'd0);
        wait_done("t4_timeout_done", 80);
        dc = cyc;
        chk("t4_timeout_cycles", 32'(dc - pc), 32'd64);
        chk("t4_timeout", 32'(o_timeout), 32'd1);
        tick(1);
        chk("t4_err_from_timeout", 32'(o_err), 32'd1);
        tick(40);
        chk("t4_no_restart", 32'(o_done), 32'd1);
        chk("t4_pulses", 32'(n_pulse - np0), 32'd3);
        i_continuous = 1'b0;

        // 5: continuous mode, saturating run counter
        i_rst = 1'b1;
        tick(2);
        i_rst = 1'b0;
        chk("t5_rst_run_cnt", 32'(o_run_cnt), 32'd0);
        chk("t5_rst_timeout", 32'(o_timeout), 32'd0);
        i_chk_finished = 2'b00;
        i_continuous   = 1'b1;
        tick(3);
        press(3);
        for (int r = 0; r < 4; r++) begin
            wait_pulse("t5_pulse", 40);
            if (r > 0) chk("t5_gap", 32'(cyc - dc), 32'd17);
            push((r < 3) ? r + 1 : 3, 2'b00, 1'b0);
            tick(3);
            i_chk_finished = 2'b11;
            wait_done("t5_done", 10);
            dc = cyc;
            i_chk_finished = 2'b00;
            if (r == 3) i_continuous = 1'b0;
        end
        tick(30);
        chk("t5_stopped", 32'(o_done), 32'd1);
        chk("t5_run_sat", 32'(o_run_cnt), 32'd3);

        // 6: clock-enable freeze, then reset mid-WAIT with enable low
        press(3);
        wait_pulse("t6_pulse", 30);
        i_aclken = 1'b0;
        tick(100);
        chk("t6_frozen_timeout", 32'(o_timeout), 32'd0);
        chk("t6_frozen_busy", 32'(o_busy), 32'd1);
        i_aclken = 1'b1;
        tick(1);
        chk("t6_resume_no_timeout", 32'(o_timeout), 32'd0);
        i_aclken = 1'b0;
        i_rst    = 1'b1;
        tick(1);
        chk("t6_rst_outputs", 32'({o_start_pulse, o_err_ch, o_err, o_timeout, o_done}), 32'd0);
        chk("t6_rst_busy", 32'(o_busy), 32'd0);
        chk("t6_rst_run_cnt", 32'(o_run_cnt), 32'd0);
        i_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_aclken = (i % 2 == 1);
            tick(1);
            chk("t6_idle_after_rst", 32'({o_busy, o_done}), 32'd0);
        end
        i_aclken = 1'b1;

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: run exceeded time limit after %0d vectors", vec);
        $fatal(1, "time limit");
    end

endmodule
